// File: rtl/pipe_pc_ctrl.sv
// pipe_pc_ctrl
//   Next-PC sequencing controller for the 5-stage pipeline. Each cycle it
//   chooses the next PC and drives the pipeline enables and flushes. The
//   candidates, highest priority first, are:
//     - a taken branch resolved in EX
//     - an illegal opcode in ID
//     - a pending external interrupt
//     - a load-use stall
//     - a JR/JALR in ID
//     - a J/JAL in ID
//     - the default, PC+4
//   It also latches interrupt requests, owns the EPC register and blocks
//   interrupts for a short window after the core leaves kernel mode.
//
// Parameters
//   IRQ_HOLDOFF  cycles after a kernel->user transition with no irq take
//   HW           width of the holdoff counter
//
// Ports
//   clk, reset     clock, synchronous active-high reset
//   irq            external interrupt (level; rising edge is latched)
//   kernel         PC[31] of the current IF-stage PC
//   id_valid       ID holds a real instruction
//   id_pc          PC of the ID instruction
//   id_jump        J/JAL in ID
//   id_jr          JR/JALR in ID
//   id_illop       undefined opcode in ID
//   ex_branch      conditional branch in EX
//   ex_taken       branch condition true
//   load_use       load-use hazard between ID and EX
//   pc_src         000 PC+4, 001 branch, 010 jump, 011 jr, 100 ILLOP, 101 XADR
//   pc_write       PC register enable
//   if_id_write    IF/ID register enable
//   if_id_flush    IF/ID -> bubble
//   id_ex_flush    ID/EX -> bubble
//   epc_we         one-cycle pulse when EPC loads
//   epc            saved exception return PC
module pipe_pc_ctrl #(
  parameter int IRQ_HOLDOFF = 2,
  parameter int HW          = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        irq,
  input  logic        kernel,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic        id_jump,
  input  logic        id_jr,
  input  logic        id_illop,
  input  logic        ex_branch,
  input  logic        ex_taken,
  input  logic        load_use,
  output logic [2:0]  pc_src,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        epc_we,
  output logic [31:0] epc
);

  localparam logic [2:0] SRC_PC4    = 3'b000;
  localparam logic [2:0] SRC_BRANCH = 3'b001;
  localparam logic [2:0] SRC_JUMP   = 3'b010;
  localparam logic [2:0] SRC_JR     = 3'b011;
  localparam logic [2:0] SRC_ILLOP  = 3'b100;
  localparam logic [2:0] SRC_XADR   = 3'b101;

  typedef enum logic [1:0] {
    IRQ_IDLE  = 2'd0,
    IRQ_PEND  = 2'd1,
    IRQ_TAKEN = 2'd2
  } irq_state_e;

  irq_state_e    state_q, state_d;
  logic          sticky_q, sticky_d;
  logic          irq_q;
  logic          kernel_q;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [31:0]   epc_q, epc_d;

  logic irq_edge;
  logic kernel_exit;
  logic holdoff_active;
  logic br_taken;
  logic illop_take;
  logic irq_take;

  assign irq_edge    = irq & ~irq_q;
  assign kernel_exit = kernel_q & ~kernel;

  // The transition cycle itself counts as the first holdoff cycle; the
  // counter is loaded at that edge and the window closes once it has
  // decremented to 1. This gives exactly IRQ_HOLDOFF blocked cycles,
  // and none when IRQ_HOLDOFF is 0.
  always_comb begin
    holdoff_active = 1'b0;
    if (kernel_exit) begin
      holdoff_active = (IRQ_HOLDOFF != 0);
    end else begin
      holdoff_active = (hold_cnt_q > HW'(1));
    end
  end

  assign br_taken   = ex_branch & ex_taken;
  // A taken branch squashes the ID instruction, so its illop is ignored.
  assign illop_take = ~br_taken & id_valid & id_illop;
  // Any branch in EX (taken or not) blocks the take; a take would
  // otherwise have to be undone when the branch resolves.
  assign irq_take   = ~reset & ~illop_take & (state_q == IRQ_PEND) & ~kernel &
                      ~holdoff_active & id_valid & ~ex_branch & ~load_use;

  // Next-PC selection and pipeline control.
  always_comb begin
    pc_src      = SRC_PC4;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    epc_we      = 1'b0;
    epc_d       = epc_q;
    if (!reset) begin
      if (br_taken) begin
        pc_src      = SRC_BRANCH;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (illop_take) begin
        pc_src      = SRC_ILLOP;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        epc_we      = 1'b1;
        // Return past the bad instruction; the supervisor bit is kept
        // so the +4 cannot carry into it.
        epc_d       = {id_pc[31], id_pc[30:0] + 31'd4};
      end else if (irq_take) begin
        pc_src      = SRC_XADR;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        epc_we      = 1'b1;
        // The interrupted instruction re-executes on return.
        epc_d       = id_pc;
      end else if (load_use) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end else if (id_valid && id_jr) begin
        pc_src      = SRC_JR;
        if_id_flush = 1'b1;
      end else if (id_valid && id_jump) begin
        pc_src      = SRC_JUMP;
        if_id_flush = 1'b1;
      end
    end
  end

  // Interrupt request FSM.
  always_comb begin
    state_d  = state_q;
    sticky_d = sticky_q;
    case (state_q)
      IRQ_IDLE: begin
        // The sticky bit holds an edge that arrived while the last
        // interrupt was still being serviced.
        if (irq_edge || sticky_q) begin
          state_d  = IRQ_PEND;
          sticky_d = 1'b0;
        end
      end
      IRQ_PEND: begin
        if (irq_take) begin
          state_d = IRQ_TAKEN;
        end
      end
      IRQ_TAKEN: begin
        if (irq_edge) begin
          sticky_d = 1'b1;
        end
        if (kernel) begin
          state_d = IRQ_IDLE;
        end
      end
      default: begin
        state_d  = IRQ_IDLE;
        sticky_d = 1'b0;
      end
    endcase
  end

  // Holdoff counter: reload on every kernel exit, otherwise count down.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (kernel_exit) begin
      hold_cnt_d = HW'(IRQ_HOLDOFF);
    end else if (hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - HW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IRQ_IDLE;
      sticky_q   <= 1'b0;
      irq_q      <= 1'b0;
      kernel_q   <= 1'b1;
      hold_cnt_q <= '0;
      epc_q      <= '0;
    end else begin
      state_q    <= state_d;
      sticky_q   <= sticky_d;
      irq_q      <= irq;
      kernel_q   <= kernel;
      hold_cnt_q <= hold_cnt_d;
      epc_q      <= epc_d;
    end
  end

  assign epc = epc_q;

endmodule

// File: tb/tb_pipe_pc_ctrl.sv
// tb_pipe_pc_ctrl
//   Directed scoreboard bench for pipe_pc_ctrl. Each cycle the stimulus is
//   driven and the hand-derived expected outputs are pushed to a queue.
//   At the falling edge the entry is popped and compared with the DUT.
module tb_pipe_pc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        irq;
  logic        kernel;
  logic        id_valid;
  logic [31:0] id_pc;
  logic        id_jump;
  logic        id_jr;
  logic        id_illop;
  logic        ex_branch;
  logic        ex_taken;
  logic        load_use;
  logic [2:0]  pc_src;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        epc_we;
  logic [31:0] epc;

  int checks_total  = 0;
  int checks_passed = 0;

  typedef struct {
    string       tag;
    logic [2:0]  src;
    logic        pw;
    logic        iw;
    logic        ifl;
    logic        efl;
    logic        we;
    logic [31:0] epc;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  pipe_pc_ctrl #(.IRQ_HOLDOFF(2), .HW(2)) dut (
    .clk(clk), .reset(reset), .irq(irq), .kernel(kernel),
    .id_valid(id_valid), .id_pc(id_pc), .id_jump(id_jump), .id_jr(id_jr),
    .id_illop(id_illop), .ex_branch(ex_branch), .ex_taken(ex_taken),
    .load_use(load_use), .pc_src(pc_src), .pc_write(pc_write),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .epc_we(epc_we), .epc(epc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      checks_passed++;
    end
  endtask

  task automatic drv(input logic rst, input logic irq_v, input logic kern,
                     input logic valid, input logic [31:0] pc, input logic jmp,
                     input logic jr_v, input logic ill, input logic br,
                     input logic tk, input logic lu);
    reset     = rst;
    irq       = irq_v;
    kernel    = kern;
    id_valid  = valid;
    id_pc     = pc;
    id_jump   = jmp;
    id_jr     = jr_v;
    id_illop  = ill;
    ex_branch = br;
    ex_taken  = tk;
    load_use  = lu;
  endtask

  // Push the expectation, compare at the falling edge, then advance past
  // the next rising edge.
  task automatic cyc(input string tag, input logic [2:0] src, input logic pw,
                     input logic iw, input logic ifl, input logic efl,
                     input logic we, input logic [31:0] epc_e);
    exp_t e;
    exp_t g;
    e.tag = tag; e.src = src; e.pw = pw; e.iw = iw;
    e.ifl = ifl; e.efl = efl; e.we = we; e.epc = epc_e;
    sb_q.push_back(e);
    @(negedge clk);
    g = sb_q.pop_front();
    check({g.tag, ".pc_src"},      {29'd0, pc_src},      {29'd0, g.src});
    check({g.tag, ".pc_write"},    {31'd0, pc_write},    {31'd0, g.pw});
    check({g.tag, ".if_id_write"}, {31'd0, if_id_write}, {31'd0, g.iw});
    check({g.tag, ".if_id_flush"}, {31'd0, if_id_flush}, {31'd0, g.ifl});
    check({g.tag, ".id_ex_flush"}, {31'd0, id_ex_flush}, {31'd0, g.efl});
    check({g.tag, ".epc_we"},      {31'd0, epc_we},      {31'd0, g.we});
    check({g.tag, ".epc"},         epc,                  g.epc);
    $display("cyc %-4s src=%03b pw=%0b iw=%0b ifl=%0b efl=%0b we=%0b epc=%08h",
             g.tag, pc_src, pc_write, if_id_write, if_id_flush, id_ex_flush, epc_we, epc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //   rst irq krn vld pc            jmp jr ill br tk lu
    // Reset: outputs at defaults even with every request asserted.
    drv(1, 0, 1, 1, 32'h0000_1000, 1, 0, 1, 1, 1, 1);
    cyc("R1", 3'b000, 1, 1, 0, 0, 0, 32'h0);
    cyc("R2", 3'b000, 1, 1, 0, 0, 0, 32'h0);

    // Illegal opcodes, EPC = PC+4 with bit 31 preserved.
    drv(0, 0, 0, 1, 32'h0040_0010, 1, 0, 1, 0, 0, 0);
    cyc("C1", 3'b100, 1, 1, 1, 1, 1, 32'h0);
    drv(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    cyc("C2", 3'b000, 1, 1, 0, 0, 0, 32'h0040_0014);
    drv(0, 0, 0, 1, 32'h8000_0010, 0, 0, 1, 0, 0, 0);
    cyc("C3", 3'b100, 1, 1, 1, 1, 1, 32'h0040_0014);
    drv(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    cyc("C4", 3'b000, 1, 1, 0, 0, 0, 32'h8000_0014);
    drv(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 1, 0, 0, 0);
    cyc("C5", 3'b100, 1, 1, 1, 1, 1, 32'h8000_0014);
    drv(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    cyc("C6", 3'b000, 1, 1, 0, 0, 0, 32'h8000_0000);

    // Load-use stall delays a JR, then jumps.
    drv(0, 0, 0, 1, 32'h0040_0100, 0, 1, 0, 0, 0, 1);
    cyc("B1", 3'b000, 0, 0, 0, 1, 0, 32'h8000_0000);
    drv(0, 0, 0, 1, 32'h0040_0100, 0, 1, 0, 0, 0, 0);
    cyc("B2", 3'b011, 1, 1, 1, 0, 0, 32'h8000_0000);
    drv(0, 0, 0, 1, 32'h0040_0104, 1, 0, 0, 1, 0, 0);
    cyc("B3", 3'b010, 1, 1, 1, 0, 0, 32'h8000_0000);
    drv(0, 0, 0, 0, 32'h0040_0108, 1, 0, 0, 0, 0, 0);
    cyc("B4", 3'b000, 1, 1, 0, 0, 0, 32'h8000_0000);
    drv(0, 0, 0, 1, 32'h0040_010C, 1, 1, 0, 0, 0, 0);
    cyc("B5", 3'b011, 1, 1, 1, 0, 0, 32'h8000_0000);

    // irq edge during an untaken branch; taken branch beats illop/jump;
    // deferred by branch and bubble; then exactly one take.
    drv(0, 1, 0, 1, 32'h0040_01F0, 0, 0, 0, 1, 0, 0);
    cyc("A1", 3'b000, 1, 1, 0, 0, 0, 32'h8000_0000);
    drv(0, 1, 0, 1, 32'h0040_01F4, 1, 0, 1, 1, 1, 0);
    cyc("A2", 3'b001, 1, 1, 1, 1, 0, 32'h8000_0000);
    drv(0, 0, 0, 1, 32'h0040_0100, 0, 0, 0, 1, 0, 0);
    cyc("A3", 3'b000, 1, 1, 0, 0, 0, 32'h8000_0000);
    drv(0, 0, 0, 0, 32'h0040_0104, 0, 0, 0, 0, 0, 0);
    cyc("A4", 3'b000, 1, 1, 0, 0, 0, 32'h8000_0000);
    drv(0, 0, 0, 1, 32'h0040_0200, 0, 0, 0, 0, 0, 0);
    cyc("A5", 3'b101, 1, 1, 1, 1, 1, 32'h8000_0000);
    drv(0, 0, 0, 1, 32'h0040_0204, 0, 0, 0, 0, 0, 0);
    cyc("A6", 3'b000, 1, 1, 0, 0, 0, 32'h0040_0200);

    // Edge while TAKEN is remembered; kernel exit then holds off 2 cycles.
    drv(0, 1, 1, 1, 32'h8000_0080, 0, 0, 0, 0, 0, 0);
    cyc("H1", 3'b000, 1, 1, 0, 0, 0, 32'h0040_0200);
    drv(0, 1, 1, 1, 32'h8000_0084, 0, 0, 0, 0, 0, 0);
    cyc("H2", 3'b000, 1, 1, 0, 0, 0, 32'h0040_0200);
    drv(0, 0, 1, 1, 32'h8000_0088, 0, 0, 0, 0, 0, 0);
    cyc("H3", 3'b000, 1, 1, 0, 0, 0, 32'h0040_0200);
    drv(0, 0, 0, 1, 32'h0040_0300, 0, 0, 0, 0, 0, 0);
    cyc("H4", 3'b000, 1, 1, 0, 0, 0, 32'h0040_0200);
    drv(0, 0, 0, 1, 32'h0040_0304, 0, 0, 0, 0, 0, 0);
    cyc("H5", 3'b000, 1, 1, 0, 0, 0, 32'h0040_0200);
    drv(0, 0, 0, 1, 32'h0040_0308, 0, 0, 0, 0, 0, 0);
    cyc("H6", 3'b101, 1, 1, 1, 1, 1, 32'h0040_0200);
    drv(0, 0, 0, 1, 32'h0040_030C, 0, 0, 0, 0, 0, 0);
    cyc("H7", 3'b000, 1, 1, 0, 0, 0, 32'h0040_0308);

    // Reset while PEND mid-holdoff: no stale take afterwards.
    drv(0, 0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    cyc("H8", 3'b000, 1, 1, 0, 0, 0, 32'h0040_0308);
    drv(0, 1, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    cyc("H9", 3'b000, 1, 1, 0, 0, 0, 32'h0040_0308);
    drv(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    cyc("H10", 3'b000, 1, 1, 0, 0, 0, 32'h0040_0308);
    cyc("H11", 3'b000, 1, 1, 0, 0, 0, 32'h0040_0308);
    drv(1, 0, 0, 1, 32'h0040_0400, 0, 0, 0, 0, 0, 0);
    cyc("H12", 3'b000, 1, 1, 0, 0, 0, 32'h0040_0308);
    drv(0, 0, 0, 1, 32'h0040_0400, 0, 0, 0, 0, 0, 0);
    cyc("H13", 3'b000, 1, 1, 0, 0, 0, 32'h0);
    drv(0, 0, 0, 1, 32'h0040_0404, 0, 0, 0, 0, 0, 0);
    cyc("H14", 3'b000, 1, 1, 0, 0, 0, 32'h0);
    cyc("H15", 3'b000, 1, 1, 0, 0, 0, 32'h0);

    // irq high through reset release is latched; illop in PEND keeps PEND.
    drv(1, 1, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    cyc("P0", 3'b000, 1, 1, 0, 0, 0, 32'h0);
    drv(0, 1, 1, 1, 32'h8000_0100, 0, 0, 0, 0, 0, 0);
    cyc("P1", 3'b000, 1, 1, 0, 0, 0, 32'h0);
    drv(0, 1, 0, 1, 32'h0040_0500, 0, 0, 1, 0, 0, 0);
    cyc("P2", 3'b100, 1, 1, 1, 1, 1, 32'h0);
    drv(0, 1, 0, 1, 32'h0040_0504, 0, 0, 0, 0, 0, 0);
    cyc("P3", 3'b000, 1, 1, 0, 0, 0, 32'h0040_0504);
    drv(0, 1, 0, 1, 32'h0040_0600, 0, 0, 0, 0, 0, 0);
    cyc("P4", 3'b101, 1, 1, 1, 1, 1, 32'h0040_0504);
    drv(0, 1, 0, 1, 32'h0040_0604, 0, 0, 0, 0, 0, 0);
    cyc("P5", 3'b000, 1, 1, 0, 0, 0, 32'h0040_0600);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
